// File: rtl/tagged_joiner_pkg.sv
// Shared crossbar definitions for the tagged joiner: error counter width and
// its saturating increment.
package tagged_joiner_pkg;

  localparam int ERR_COUNT_WIDTH = 16;

  function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(input logic [ERR_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tagged_joiner_skid.sv
// Tagged skid buffer: registered output, registered ready, full throughput.
// Beats land in the main register; the skid register only catches a beat on a stall.
module tagged_joiner_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_q, skid_q;
  logic         main_vld, skid_vld;

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (!main_vld || out_ready) begin
      // in_ready is low while the skid holds a beat, so nothing arrives then
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= in_valid;
        if (in_valid) main_q <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_q   <= in_data;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/tagged_joiner.sv
// Joins NUM_STREAMS tagged streams beat by beat through one-entry slots.
// Define TAGGED_JOINER_CHECK_EN to build the tag/last mismatch checker (err, err_count).
module tagged_joiner
  import tagged_joiner_pkg::*;
#(
  parameter int NUM_STREAMS     = 2,
  parameter int DATA_W          = 32,
  parameter int TAG_WIDTH       = 8,
  parameter int KEEP_W          = 4,
  parameter int NUM_SKID_STAGES = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_STREAMS-1:0][DATA_W-1:0]      in_data,
  input  logic [NUM_STREAMS-1:0][TAG_WIDTH-1:0]   in_tag,
  input  logic [NUM_STREAMS-1:0][KEEP_W-1:0]      in_keep,
  input  logic [NUM_STREAMS-1:0]                  in_last,
  input  logic [NUM_STREAMS-1:0]                  in_valid,
  output logic [NUM_STREAMS-1:0]                  in_ready,
  output logic [NUM_STREAMS-1:0][DATA_W-1:0]      out_data,
  output logic [TAG_WIDTH-1:0]                    out_tag,
  output logic [KEEP_W-1:0]                       out_keep,
  output logic                                    out_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    err,
  output logic [ERR_COUNT_WIDTH-1:0]              err_count
);

  typedef struct packed {
    logic [NUM_STREAMS-1:0][DATA_W-1:0] data;
    logic [TAG_WIDTH-1:0]               tag;
    logic [KEEP_W-1:0]                  keep;
    logic                               last;
  } joined_t;

  logic [NUM_STREAMS-1:0][DATA_W-1:0]    slot_data;
  logic [NUM_STREAMS-1:0][TAG_WIDTH-1:0] slot_tag;
  logic [NUM_STREAMS-1:0][KEEP_W-1:0]    slot_keep;
  logic [NUM_STREAMS-1:0]                slot_last;
  logic [NUM_STREAMS-1:0]                full;
  logic [NUM_STREAMS-1:0]                capture;
  logic                                  join_valid, join_fire;

  joined_t [NUM_SKID_STAGES:0] stg_data;
  logic    [NUM_SKID_STAGES:0] stg_valid, stg_ready;

  assign join_valid = &full;
  assign join_fire  = join_valid && stg_ready[0];
  assign in_ready   = ~full | {NUM_STREAMS{join_fire}};
  assign capture    = in_valid & in_ready;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full[i]      <= 1'b0;
        slot_data[i] <= '0;
        slot_tag[i]  <= '0;
        slot_keep[i] <= '0;
        slot_last[i] <= 1'b0;
      end else if (capture[i]) begin
        // a capture wins over a same-cycle release: the slot stays full
        full[i]      <= 1'b1;
        slot_data[i] <= in_data[i];
        slot_tag[i]  <= in_tag[i];
        slot_keep[i] <= in_keep[i];
        slot_last[i] <= in_last[i];
      end else if (join_fire) begin
        full[i] <= 1'b0;
      end
    end
  end

  assign stg_data[0].data = slot_data;
  assign stg_data[0].tag  = slot_tag[0];
  assign stg_data[0].keep = slot_keep[0];
  assign stg_data[0].last = slot_last[0];
  assign stg_valid[0]     = join_valid;

  for (genvar s = 0; s < NUM_SKID_STAGES; s++) begin : g_skid
    tagged_joiner_skid #(.W($bits(joined_t))) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (stg_data[s]),
      .in_valid  (stg_valid[s]),
      .in_ready  (stg_ready[s]),
      .out_data  (stg_data[s+1]),
      .out_valid (stg_valid[s+1]),
      .out_ready (stg_ready[s+1])
    );
  end

  assign stg_ready[NUM_SKID_STAGES] = out_ready;
  assign out_valid = stg_valid[NUM_SKID_STAGES];
  assign out_data  = stg_data[NUM_SKID_STAGES].data;
  assign out_tag   = stg_data[NUM_SKID_STAGES].tag;
  assign out_keep  = stg_data[NUM_SKID_STAGES].keep;
  assign out_last  = stg_data[NUM_SKID_STAGES].last;

`ifdef TAGGED_JOINER_CHECK_EN
  logic mismatch;

  always_comb begin
    mismatch = 1'b0;
    for (int i = 1; i < NUM_STREAMS; i++)
      if (slot_tag[i] != slot_tag[0] || slot_last[i] != slot_last[0]) mismatch = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (join_fire && mismatch) begin
      err       <= 1'b1;
      err_count <= sat_inc(err_count);
    end
  end
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule
